// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and constants for the button press classifier.
//   - btn_state_e    : gesture FSM states
//   - *_TICKS_DEF    : default timing for a 1 kHz tick
//   - timer_width()  : bits needed to count up to the larger timing limit
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } btn_state_e;

  // Defaults for a 1 kHz tick: 1 s for a long press, 300 ms double-press gap.
  localparam int unsigned LONG_TICKS_DEF = 32'd1000;
  localparam int unsigned GAP_TICKS_DEF  = 32'd300;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // The timer must be able to represent the larger limit itself.
  function automatic int unsigned timer_width(input int unsigned long_t,
                                              input int unsigned gap_t);
    return $clog2(max_u(long_t, gap_t) + 32'd1);
  endfunction

endpackage

// File: rtl/press_tick_timer.sv
// -----------------------------------------------------------------------------
// press_tick_timer
// Saturating tick counter used to time press and gap phases.
// Ports:
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset
//   clr   in   synchronous clear (takes priority over tick)
//   tick  in   timebase enable, one count per high cycle
//   count out  current tick count, saturates at all-ones
//   hit   out  tick is high and count == LIMIT-1 (LIMIT reached this cycle)
// -----------------------------------------------------------------------------
module press_tick_timer #(
  parameter int unsigned W     = 4,
  parameter int unsigned LIMIT = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         hit
);

  localparam logic [W-1:0] CNT_MAX   = {W{1'b1}};
  localparam logic [W-1:0] LIMIT_M1  = W'(LIMIT - 32'd1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise count ticks until saturation.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (tick && (count_q != CNT_MAX)) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign hit   = tick & (count_q == LIMIT_M1);

endmodule

// File: rtl/btn_press_classifier.sv
// -----------------------------------------------------------------------------
// btn_press_classifier
// Classifies gestures on a debounced button into short, long and double
// presses, timed by an external tick enable.
// Ports:
//   clk          in   system clock
//   rstn         in   asynchronous active-low reset
//   tick         in   single-cycle timebase enable
//   btn_db       in   debounced button level, 1 = pressed
//   short_press  out  one-clk pulse: single short press recognised
//   long_press   out  one-clk pulse: hold reached LONG_TICKS
//   double_press out  one-clk pulse: second press within GAP_TICKS
//   held         out  level, high while in LONG_HOLD
//   event_cnt    out  wrapping count of all emitted pulses
// -----------------------------------------------------------------------------
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter int unsigned LONG_TICKS = LONG_TICKS_DEF,
  parameter int unsigned GAP_TICKS  = GAP_TICKS_DEF,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick,
  input  logic             btn_db,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic             held,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int unsigned  TW        = timer_width(LONG_TICKS, GAP_TICKS);
  localparam logic [TW-1:0] GAP_M1   = TW'(GAP_TICKS - 32'd1);

  btn_state_e       state_q, state_d;
  logic             btn_q;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rise_s;
  logic             fall_s;
  logic             timer_clr_s;
  logic [TW-1:0]    timer_count_s;
  logic             long_hit_s;
  logic             gap_hit_s;

  assign rise_s = btn_db & ~btn_q;
  assign fall_s = ~btn_db & btn_q;

  // Every state change restarts timing from zero in the new state.
  assign timer_clr_s = (state_d != state_q);

  // The shared timer flags the long limit directly; the gap limit is decoded
  // here from its count since both limits run on the same counter.
  assign gap_hit_s = tick & (timer_count_s == GAP_M1);

  press_tick_timer #(
    .W     (TW),
    .LIMIT (LONG_TICKS)
  ) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (timer_clr_s),
    .tick  (tick),
    .count (timer_count_s),
    .hit   (long_hit_s)
  );

  // Gesture FSM next state and event decode; edges take priority over limits.
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = PRESS1;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS1: begin
        if (fall_s) begin
          state_d = WAIT2;
        end else if (long_hit_s) begin
          long_d  = 1'b1;
          state_d = LONG_HOLD;
        end else begin
          state_d = PRESS1;
        end
      end
      LONG_HOLD: begin
        if (fall_s) begin
          state_d = IDLE;
        end else begin
          state_d = LONG_HOLD;
        end
      end
      WAIT2: begin
        if (rise_s) begin
          state_d = PRESS2;
        end else if (gap_hit_s) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT2;
        end
      end
      PRESS2: begin
        if (fall_s) begin
          dbl_d   = 1'b1;
          state_d = IDLE;
        end else if (long_hit_s) begin
          // A held second press still counts as a double, not a long press.
          dbl_d   = 1'b1;
          state_d = LONG_HOLD;
        end else begin
          state_d = PRESS2;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Held level and wrapping event counter, registered alongside the pulses.
  always_comb begin
    held_d = (state_d == LONG_HOLD);
    if (short_d || long_d || dbl_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, edge-detect history and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      btn_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      btn_q   <= btn_db;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = dbl_q;
  assign held         = held_q;
  assign event_cnt    = cnt_q;

endmodule
